// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM arbiter slice.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    CLEAR
  } ram_arb_state_t;

  // Registered read-response tag: which requester owns the data arriving next cycle.
  typedef struct packed {
    logic       vld;
    logic [1:0] id;
  } rsp_tag_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  logic [31:0] idx;
  logic        found;

  // Scan ptr, ptr+1, ... (mod N) and grant the first requester found.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one 1W/1R registered-read RAM among NUM_REQ clients.
// Owns the RAM reset (init after rst_n release, and on clr).
// Optional per-requester grant counters: define RAM_ARB_STATS_EN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic                          clr,
  output logic                          clr_done,
  output logic                          ram_rst,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_wr_addr,
  output logic [DATA_WIDTH-1:0]         ram_wr_din,
  output logic                          ram_re,
  output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         ram_rd_dout
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt
`endif
);

  localparam int IDW = id_width(NUM_REQ);

  ram_arb_state_t       state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  rsp_tag_t             tag_q, tag_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDW-1:0]       arb_id;
  logic                 grant_en;
  logic [NUM_REQ-1:0]   accept;
  logic                 any_accept;
  logic                 sel_write;
  logic [31:0]          sel;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  // State, round-robin pointer and read-response tag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= INIT;
      rr_ptr_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      tag_q    <= tag_d;
    end
  end

  // FSM next state; control outputs are forced low while rst_n is asserted
  // because the reset is synchronous and state_q may still hold RUN.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    ram_rst  = 1'b0;
    clr_done = 1'b0;
    case (state_q)
      INIT: begin
        ram_rst = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (clr) state_d = CLEAR;
        else     grant_en = 1'b1;
      end
      CLEAR: begin
        ram_rst  = 1'b1;
        clr_done = 1'b1;
        state_d  = RUN;
      end
      default: state_d = INIT;
    endcase
    if (!rst_n) begin
      grant_en = 1'b0;
      ram_rst  = 1'b0;
      clr_done = 1'b0;
    end
  end

  // Grant, RAM port muxing, pointer advance and response tag capture.
  always_comb begin
    req_ready   = grant_en ? arb_gnt : '0;
    accept      = req_valid & req_ready;
    any_accept  = |accept;
    sel         = 32'(arb_id);
    sel_write   = req_write[arb_id];
    ram_we      = any_accept & sel_write;
    ram_re      = any_accept & ~sel_write;
    ram_wr_addr = req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
    ram_wr_din  = req_wdata[sel*DATA_WIDTH +: DATA_WIDTH];
    ram_rd_addr = req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
    rr_ptr_d    = any_accept ? IDW'((sel + 32'd1) % NUM_REQ) : rr_ptr_q;
    tag_d.vld   = ram_re;
    tag_d.id    = 2'(arb_id);
  end

  // Route registered read data to the requester recorded in the tag.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (rst_n && tag_q.vld) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        rsp_valid[i] = (tag_q.id == 2'(i));
      end
      rsp_data = ram_rd_dout;
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [NUM_REQ*CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Saturating per-requester accept counters.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (accept[i] && (cnt_q[i*CNT_WIDTH +: CNT_WIDTH] != '1)) begin
        cnt_d[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
      end
    end
  end

  // Counter register; cleared only by rst_n, not by clr.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`else
  logic [CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [7:0]  rsp_data;
  logic        clr, clr_done, ram_rst, ram_we, ram_re;
  logic [3:0]  ram_wr_addr, ram_rd_addr;
  logic [7:0]  ram_wr_din, ram_rd_dout;
`ifdef RAM_ARB_STATS_EN
  logic [2*CNT_W-1:0] grant_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int exp_ptr = 0;
  logic [7:0] model_mem [16];
  logic [9:0] sb [$];
  logic [9:0] e;

  always #5 clk = ~clk;

  ram_arbiter #(
    .NUM_REQ    (2),
    .ADDR_WIDTH (4),
    .DATA_WIDTH (8),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .clr         (clr),
    .clr_done    (clr_done),
    .ram_rst     (ram_rst),
    .ram_we      (ram_we),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_din  (ram_wr_din),
    .ram_re      (ram_re),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_dout (ram_rd_dout)
`ifdef RAM_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  // Behavioural 1W/1R RAM with registered read and synchronous clear.
  logic [7:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_rst) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= 8'h00;
      ram_rd_dout <= 8'h00;
    end else begin
      if (ram_we) ram_mem[ram_wr_addr] <= ram_wr_din;
      if (ram_re) ram_rd_dout <= ram_mem[ram_rd_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [1:0] exp_gnt(input logic [1:0] v, input int p);
    if (p == 0) return v[0] ? 2'b01 : (v[1] ? 2'b10 : 2'b00);
    else        return v[1] ? 2'b10 : (v[0] ? 2'b01 : 2'b00);
  endfunction

  function automatic int sat(input int n);
    int mx;
    mx = (CNT_W >= 31) ? 32'h7fffffff : ((1 << CNT_W) - 1);
    return (n > mx) ? mx : n;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [3:0] a0,
                       input logic [3:0] a1, input logic [7:0] d0, input logic [7:0] d1);
    req_valid = v;
    req_write = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    exp_ptr = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    drive(2'b11, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    next_cycle();
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
    checks++; if (ram_rst !== 1'b0) begin errors++; $display("FAIL rst_ram_rst got=%b exp=0", ram_rst); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if ({clr_done, ram_we, ram_re} !== 3'b000) begin errors++; $display("FAIL rst_ctrl got=%b exp=000", {clr_done, ram_we, ram_re}); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ram_rst !== 1'b1) begin errors++; $display("FAIL init_ram_rst got=%b exp=1", ram_rst); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL init_ready got=%b exp=00", req_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (ram_rst !== 1'b0) begin errors++; $display("FAIL run_ram_rst got=%b exp=0", ram_rst); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL run_ready got=%b exp=01", req_ready); end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    clear_model();
    next_cycle();
  endtask

  task automatic test_write_read();
    logic [1:0] g;
    drive(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00);
    @(negedge clk);
    g = exp_gnt(2'b01, exp_ptr);
    checks++; if (req_ready !== g) begin errors++; $display("FAIL wr_ready got=%b exp=%b", req_ready, g); end
    checks++; if ({ram_we, ram_re, ram_wr_addr, ram_wr_din} !== {1'b1, 1'b0, 4'd3, 8'hA5})
      begin errors++; $display("FAIL wr_port got=%b/%b/%h/%h exp=1/0/3/a5", ram_we, ram_re, ram_wr_addr, ram_wr_din); end
    model_mem[3] = 8'hA5;
    exp_ptr = g[1] ? 0 : 1;
    next_cycle();
    drive(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    g = exp_gnt(2'b01, exp_ptr);
    checks++; if (req_ready !== g) begin errors++; $display("FAIL rd_ready got=%b exp=%b", req_ready, g); end
    checks++; if ({ram_re, ram_we, ram_rd_addr} !== {1'b1, 1'b0, 4'd3})
      begin errors++; $display("FAIL rd_port got=%b/%b/%h exp=1/0/3", ram_re, ram_we, ram_rd_addr); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_early_rsp got=%b exp=00", rsp_valid); end
    sb.push_back({2'd0, model_mem[3]});
    exp_ptr = g[1] ? 0 : 1;
    next_cycle();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (rsp_valid !== ((e[9:8] == 2'd0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL wr_rd_rsp_valid got=%b id=%0d", rsp_valid, e[9:8]); end
    checks++; if (rsp_data !== e[7:0]) begin errors++; $display("FAIL wr_rd_rsp_data got=%h exp=%h", rsp_data, e[7:0]); end
    next_cycle();
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_data} !== 10'd0) begin errors++; $display("FAIL rsp_idle got=%b/%h exp=00/00", rsp_valid, rsp_data); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [1:0] g;
    logic [3:0] a;
    drive(2'b10, 2'b10, 4'd0, 4'd1, 8'h00, 8'h5A);
    @(negedge clk);
    g = exp_gnt(2'b10, exp_ptr);
    checks++; if ({req_ready, ram_we, ram_wr_addr} !== {g, 1'b1, 4'd1}) begin errors++; $display("FAIL b2b_wr1 got=%b/%b/%h exp=%b/1/1", req_ready, ram_we, ram_wr_addr, g); end
    model_mem[1] = 8'h5A;
    exp_ptr = g[1] ? 0 : 1;
    next_cycle();
    drive(2'b01, 2'b01, 4'd2, 4'd0, 8'hC3, 8'h00);
    @(negedge clk);
    g = exp_gnt(2'b01, exp_ptr);
    checks++; if ({req_ready, ram_we, ram_wr_addr} !== {g, 1'b1, 4'd2}) begin errors++; $display("FAIL b2b_wr2 got=%b/%b/%h exp=%b/1/2", req_ready, ram_we, ram_wr_addr, g); end
    model_mem[2] = 8'hC3;
    exp_ptr = g[1] ? 0 : 1;
    next_cycle();
    for (int c = 0; c < 6; c++) begin
      drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00);
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++; if (rsp_valid !== ((e[9:8] == 2'd0) ? 2'b01 : 2'b10) || rsp_data !== e[7:0])
          begin errors++; $display("FAIL b2b_rsp[%0d] got=%b/%h exp_id=%0d data=%h", c, rsp_valid, rsp_data, e[9:8], e[7:0]); end
      end else begin
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL b2b_rsp_none[%0d] got=%b exp=00", c, rsp_valid); end
      end
      g = exp_gnt(2'b11, exp_ptr);
      a = g[1] ? 4'd2 : 4'd1;
      checks++; if ({req_ready, ram_re, ram_rd_addr} !== {g, 1'b1, a})
        begin errors++; $display("FAIL b2b_grant[%0d] got=%b/%b/%h exp=%b/1/%h", c, req_ready, ram_re, ram_rd_addr, g, a); end
      sb.push_back({g[1] ? 2'd1 : 2'd0, model_mem[a]});
      exp_ptr = g[1] ? 0 : 1;
      next_cycle();
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (rsp_valid !== ((e[9:8] == 2'd0) ? 2'b01 : 2'b10) || rsp_data !== e[7:0])
      begin errors++; $display("FAIL b2b_rsp_last got=%b/%h exp_id=%0d data=%h", rsp_valid, rsp_data, e[9:8], e[7:0]); end
    next_cycle();
  endtask

  task automatic test_clear();
    logic [1:0] g;
    drive(2'b01, 2'b01, 4'd5, 4'd0, 8'h3C, 8'h00);
    @(negedge clk);
    g = exp_gnt(2'b01, exp_ptr);
    checks++; if ({req_ready, ram_we, ram_wr_addr, ram_wr_din} !== {g, 1'b1, 4'd5, 8'h3C}) begin errors++; $display("FAIL clr_wr got=%b/%b/%h/%h", req_ready, ram_we, ram_wr_addr, ram_wr_din); end
    model_mem[5] = 8'h3C;
    exp_ptr = g[1] ? 0 : 1;
    next_cycle();
    drive(2'b01, 2'b00, 4'd5, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    g = exp_gnt(2'b01, exp_ptr);
    checks++; if ({req_ready, ram_re} !== {g, 1'b1}) begin errors++; $display("FAIL clr_pre_rd got=%b/%b exp=%b/1", req_ready, ram_re, g); end
    sb.push_back({2'd0, model_mem[5]});
    exp_ptr = g[1] ? 0 : 1;
    next_cycle();
    clr = 1'b1;
    @(negedge clk);
    checks++; if ({req_ready, ram_re, clr_done, ram_rst} !== 5'b00000) begin errors++; $display("FAIL clr_req_cycle got=%b/%b/%b/%b exp=00/0/0/0", req_ready, ram_re, clr_done, ram_rst); end
    e = sb.pop_front();
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== e[7:0]) begin errors++; $display("FAIL clr_inflight got=%b/%h exp=01/%h", rsp_valid, rsp_data, e[7:0]); end
    next_cycle();
    @(negedge clk);
    checks++; if ({clr_done, ram_rst} !== 2'b11) begin errors++; $display("FAIL clr_done got=%b/%b exp=1/1", clr_done, ram_rst); end
    checks++; if ({req_ready, rsp_valid} !== 4'b0000) begin errors++; $display("FAIL clr_state got=%b/%b exp=00/00", req_ready, rsp_valid); end
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    next_cycle();
    clr = 1'b0;
    @(negedge clk);
    g = exp_gnt(2'b01, exp_ptr);
    checks++; if ({clr_done, ram_rst} !== 2'b00) begin errors++; $display("FAIL clr_once got=%b/%b exp=0/0", clr_done, ram_rst); end
    checks++; if ({req_ready, ram_re, ram_rd_addr} !== {g, 1'b1, 4'd5}) begin errors++; $display("FAIL clr_post_rd got=%b/%b/%h exp=%b/1/5", req_ready, ram_re, ram_rd_addr, g); end
    sb.push_back({2'd0, model_mem[5]});
    exp_ptr = g[1] ? 0 : 1;
    next_cycle();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== e[7:0]) begin errors++; $display("FAIL clr_readback got=%b/%h exp=01/%h", rsp_valid, rsp_data, e[7:0]); end
    next_cycle();
  endtask

  task automatic test_reset_midread();
    logic [1:0] g;
    drive(2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00);
    @(negedge clk);
    g = exp_gnt(2'b10, exp_ptr);
    checks++; if ({req_ready, ram_re} !== {g, 1'b1}) begin errors++; $display("FAIL mid_rd got=%b/%b exp=%b/1", req_ready, ram_re, g); end
    next_cycle();
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_data} !== 10'd0) begin errors++; $display("FAIL mid_drop got=%b/%h exp=00/00", rsp_valid, rsp_data); end
    next_cycle();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_drop2 got=%b exp=00", rsp_valid); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ram_rst !== 1'b1) begin errors++; $display("FAIL mid_reinit got=%b exp=1", ram_rst); end
    next_cycle();
    clear_model();
  endtask

`ifdef RAM_ARB_STATS_EN
  task automatic test_stats();
    logic [1:0] g;
    int n0;
    int n1;
    n0 = 0;
    n1 = 0;
    @(negedge clk);
    checks++; if (grant_cnt !== '0) begin errors++; $display("FAIL cnt_reset got=%h exp=0", grant_cnt); end
    for (int c = 0; c < 14; c++) begin
      if (c < 8) drive(2'b11, 2'b11, 4'(c), 4'(c + 8), 8'(c), 8'(c + 16));
      else       drive(2'b01, 2'b01, 4'(c), 4'd0, 8'(c), 8'h00);
      @(negedge clk);
      g = exp_gnt(req_valid, exp_ptr);
      checks++; if (req_ready !== g) begin errors++; $display("FAIL cnt_grant[%0d] got=%b exp=%b", c, req_ready, g); end
      if (g[0]) n0++;
      if (g[1]) n1++;
      exp_ptr = g[1] ? 0 : 1;
      next_cycle();
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    clr = 1'b1;
    next_cycle();
    clr = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++; if (grant_cnt[CNT_W-1:0] !== CNT_W'(sat(n0))) begin errors++; $display("FAIL cnt_req0 got=%0d exp=%0d", grant_cnt[CNT_W-1:0], sat(n0)); end
    checks++; if (grant_cnt[2*CNT_W-1:CNT_W] !== CNT_W'(sat(n1))) begin errors++; $display("FAIL cnt_req1 got=%0d exp=%0d", grant_cnt[2*CNT_W-1:CNT_W], sat(n1)); end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_clear();
    test_reset_midread();
`ifdef RAM_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
